// File: rtl/voice_endpoint_detect.sv
// Voice endpoint detector: per-frame energy of the PCM stream, a hysteresis
// FSM that finds speech onset/end (vq_start/vq_stop), and FIFO-level-gated
// forwarding of samples to MFCC_VQ while speech is active.
module voice_endpoint_detect #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 256,
    parameter int ENERGY_W   = 40,
    parameter int ON_FRAMES  = 3,
    parameter int OFF_FRAMES = 8,
    parameter int LEVEL_MAX  = 2047
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [ENERGY_W-1:0]          energy_thr,
    input  logic                         voice_en_in,
    input  logic signed [DATA_WIDTH-1:0] voice_data_in,
    input  logic [11:0]                  wr_water_level,
    output logic                         voice_en_out,
    output logic signed [DATA_WIDTH-1:0] voice_data_out,
    output logic                         vq_start,
    output logic                         vq_stop,
    output logic                         speech_active,
    output logic                         overflow,
    output logic [ENERGY_W-1:0]          frame_energy,
    output logic                         frame_energy_vld
);

    localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int FC_MAX = (ON_FRAMES > OFF_FRAMES) ? ON_FRAMES : OFF_FRAMES;
    localparam int FC_W   = $clog2(FC_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [FC_W-1:0]  ON_LAST  = FC_W'(ON_FRAMES - 1);
    localparam logic [FC_W-1:0]  OFF_LAST = FC_W'(OFF_FRAMES - 1);

    typedef enum logic [2:0] {IDLE, SILENCE, ONSET, SPEECH, HANGOVER} state_t;

    state_t                 state;
    logic [FC_W-1:0]        fc;
    logic [ENERGY_W-1:0]    acc;
    logic [CNT_W-1:0]       cnt;

    logic signed [2*DATA_WIDTH-1:0] data_ext;
    logic signed [2*DATA_WIDTH-1:0] sq_s;
    logic [ENERGY_W-1:0]            sq_ext;
    logic                           loud;
    logic                           run;
    logic                           go_speech;
    logic                           go_stop;
    logic                           fwd_take;
    logic                           level_ok;

    // Square is always non-negative and fits 2*DATA_WIDTH bits, so the low
    // half of the product is exact.
    assign data_ext  = {{DATA_WIDTH{voice_data_in[DATA_WIDTH-1]}}, voice_data_in};
    assign sq_s      = data_ext * data_ext;
    assign sq_ext    = ENERGY_W'($unsigned(sq_s));

    assign loud      = frame_energy > energy_thr;
    assign run       = enable && (state != IDLE);

    // Transitions that emit a strobe, shared by the FSM and the overflow flag.
    assign go_speech = enable && frame_energy_vld && loud &&
                       (((state == SILENCE) && (ON_FRAMES == 1)) ||
                        ((state == ONSET) && (fc == ON_LAST)));
    assign go_stop   = enable && frame_energy_vld && !loud &&
                       (((state == SPEECH) && (OFF_FRAMES == 1)) ||
                        ((state == HANGOVER) && (fc == OFF_LAST)));

    // The vq_start cycle itself never forwards; the first sample after it does.
    assign fwd_take  = voice_en_in && speech_active && !vq_start;
    assign level_ok  = wr_water_level < 12'(LEVEL_MAX);

    // Frame energy accumulator: sum of squares over FRAME_LEN samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here carries state that is observable after reset, so all of them are reset; nothing is left to power-up value.
            acc              <= '0;
            cnt              <= '0;
            frame_energy     <= '0;
            frame_energy_vld <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only in clocked blocks, so every reader sees the pre-edge value regardless of block order.
            frame_energy_vld <= 1'b0;
            if (!run) begin
                acc <= '0;
                cnt <= '0;
            end else if (voice_en_in) begin
                if (cnt == CNT_LAST) begin
                    frame_energy     <= acc + sq_ext;
                    frame_energy_vld <= 1'b1;
                    acc              <= '0;
                    cnt              <= '0;
                end else begin
                    acc <= acc + sq_ext;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Hysteresis FSM with registered strobes and speech_active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            fc            <= '0;
            vq_start      <= 1'b0;
            vq_stop       <= 1'b0;
            speech_active <= 1'b0;
        end else begin
            vq_start <= 1'b0;
            vq_stop  <= 1'b0;
            if (!enable) begin
                if ((state == SPEECH) || (state == HANGOVER)) vq_stop <= 1'b1;
                state         <= IDLE;
                fc            <= '0;
                speech_active <= 1'b0;
            end else if (go_speech) begin
                state         <= SPEECH;
                fc            <= '0;
                vq_start      <= 1'b1;
                speech_active <= 1'b1;
            end else if (go_stop) begin
                state         <= SILENCE;
                fc            <= '0;
                vq_stop       <= 1'b1;
                speech_active <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= SILENCE;
                    SILENCE: begin
                        if (frame_energy_vld && loud) begin
                            state <= ONSET;
                            fc    <= FC_W'(1);
                        end
                    end
                    ONSET: begin
                        if (frame_energy_vld) begin
                            if (loud) begin
                                fc <= fc + 1'b1;
                            end else begin
                                state <= SILENCE;
                                fc    <= '0;
                            end
                        end
                    end
                    SPEECH: begin
                        if (frame_energy_vld && !loud) begin
                            state <= HANGOVER;
                            fc    <= FC_W'(1);
                        end
                    end
                    HANGOVER: begin
                        if (frame_energy_vld) begin
                            if (loud) begin
                                state <= SPEECH;
                                fc    <= '0;
                            end else begin
                                fc <= fc + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Sample forwarding gated by the MFCC_VQ FIFO level; sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voice_en_out   <= 1'b0;
            voice_data_out <= '0;
            overflow       <= 1'b0;
        end else begin
            voice_en_out <= 1'b0;
            if (go_speech) begin
                overflow <= 1'b0;
            end else if (fwd_take) begin
                if (level_ok) begin
                    voice_en_out   <= 1'b1;
                    voice_data_out <= voice_data_in;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_voice_endpoint_detect.sv
// Self-checking bench for voice_endpoint_detect: frame-level vector table
// followed by hand-written sequences for latency, backpressure, abort and reset.
module tb_voice_endpoint_detect;

    localparam int DW = 16;
    localparam int EW = 40;
    localparam int FL = 256;

    localparam logic [EW-1:0] T1   = 40'd100_000_000;
    localparam logic [EW-1:0] E1   = 40'd256_000_000;
    localparam logic [EW-1:0] EH   = 40'd64_000_000;
    localparam logic [EW-1:0] EMAX = 40'd274_877_906_944;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable = 1'b0;
    logic [EW-1:0]        energy_thr = T1;
    logic                 voice_en_in = 1'b0;
    logic signed [DW-1:0] voice_data_in = '0;
    logic [11:0]          wr_water_level = 12'd100;
    logic                 voice_en_out;
    logic signed [DW-1:0] voice_data_out;
    logic                 vq_start;
    logic                 vq_stop;
    logic                 speech_active;
    logic                 overflow;
    logic [EW-1:0]        frame_energy;
    logic                 frame_energy_vld;

    voice_endpoint_detect dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .energy_thr       (energy_thr),
        .voice_en_in      (voice_en_in),
        .voice_data_in    (voice_data_in),
        .wr_water_level   (wr_water_level),
        .voice_en_out     (voice_en_out),
        .voice_data_out   (voice_data_out),
        .vq_start         (vq_start),
        .vq_stop          (vq_stop),
        .speech_active    (speech_active),
        .overflow         (overflow),
        .frame_energy     (frame_energy),
        .frame_energy_vld (frame_energy_vld)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Event counters sampled on the falling edge, away from the active edge.
    int fwd_total   = 0;
    int stop_total  = 0;
    int clash_total = 0;
    always @(negedge clk) begin
        if (voice_en_out)         fwd_total   <= fwd_total + 1;
        if (vq_stop)              stop_total  <= stop_total + 1;
        if (vq_start && vq_stop)  clash_total <= clash_total + 1;
    end

    typedef struct {
        logic [EW-1:0]        thr;
        logic signed [DW-1:0] value;
        logic [EW-1:0]        energy;
        logic                 start;
        logic                 stop;
        logic                 active;
        logic                 ovf;
        int                   fwd;
    } vec_t;

    vec_t tbl [31];

    function automatic vec_t mk(input logic [EW-1:0] thr, input logic signed [DW-1:0] value,
                                input logic [EW-1:0] energy, input logic start, input logic stop,
                                input logic active, input logic ovf, input int fwd);
        vec_t v;
        v.thr = thr; v.value = value; v.energy = energy;
        v.start = start; v.stop = stop; v.active = active; v.ovf = ovf; v.fwd = fwd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full frame of constant samples, then the vld cycle and the cycle after.
    task automatic run_frame(input string tag, input vec_t v);
        int base;
        energy_thr = v.thr;
        base = fwd_total;
        for (int i = 0; i < FL; i++) begin
            voice_en_in   = 1'b1;
            voice_data_in = v.value;
            tick();
        end
        voice_en_in = 1'b0;
        check({tag, ".vld"}, 64'(frame_energy_vld), 64'd1);
        check({tag, ".energy"}, 64'(frame_energy), 64'(v.energy));
        tick();
        check({tag, ".vq_start"}, 64'(vq_start), 64'(v.start));
        check({tag, ".vq_stop"}, 64'(vq_stop), 64'(v.stop));
        check({tag, ".active"}, 64'(speech_active), 64'(v.active));
        check({tag, ".overflow"}, 64'(overflow), 64'(v.ovf));
        check({tag, ".fwd_count"}, 64'(fwd_total - base), 64'(v.fwd));
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        int stop_before;

        // Frame-level vectors: thr, sample, expected energy, start, stop, active, ovf, forwarded count.
        tbl[0]  = mk(T1, 16'sd1000, E1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(T1, 16'sd1000, E1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(T1, 16'sd0,    '0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(T1, 16'sd1000, E1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(T1, 16'sd500,  EH, 0, 0, 0, 0, 0);
        tbl[5]  = mk(T1, 16'sd1000, E1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(T1, 16'sd1000, E1, 0, 0, 0, 0, 0);
        tbl[7]  = mk(T1, 16'sd1000, E1, 1, 0, 1, 0, 0);
        tbl[8]  = mk(T1, 16'sd1000, E1, 0, 0, 1, 0, 255);
        for (int i = 9; i <= 15; i++) tbl[i] = mk(T1, 16'sd0, '0, 0, 0, 1, 0, 256);
        tbl[16] = mk(T1, 16'sd1000, E1, 0, 0, 1, 0, 256);
        for (int i = 17; i <= 23; i++) tbl[i] = mk(T1, 16'sd0, '0, 0, 0, 1, 0, 256);
        tbl[24] = mk(T1, 16'sd0,    '0, 0, 1, 0, 0, 256);
        tbl[25] = mk(T1, 16'sd0,    '0, 0, 0, 0, 0, 0);
        tbl[26] = mk(T1,       16'sh8000, EMAX, 0, 0, 0, 0, 0);
        tbl[27] = mk(EMAX,     16'sh8000, EMAX, 0, 0, 0, 0, 0);
        tbl[28] = mk(EMAX - 1, 16'sh8000, EMAX, 0, 0, 0, 0, 0);
        tbl[29] = mk(T1, 16'sd1000, E1, 0, 0, 0, 0, 0);
        tbl[30] = mk(T1, 16'sd1000, E1, 1, 0, 1, 0, 0);

        // Reset state.
        #12;
        check("reset.en_out", 64'(voice_en_out), 64'd0);
        check("reset.start", 64'(vq_start), 64'd0);
        check("reset.stop", 64'(vq_stop), 64'd0);
        check("reset.active", 64'(speech_active), 64'd0);
        check("reset.energy", 64'(frame_energy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Samples while IDLE must not accumulate.
        for (int i = 0; i < 20; i++) begin
            voice_en_in   = 1'b1;
            voice_data_in = 16'sd1000;
            tick();
        end
        voice_en_in = 1'b0;
        check("idle.vld", 64'(frame_energy_vld), 64'd0);
        enable = 1'b1;
        tick();

        for (int i = 0; i < 31; i++) run_frame($sformatf("v%0d", i), tbl[i]);

        // Now in the vq_start cycle: its sample is not forwarded.
        voice_en_in   = 1'b1;
        voice_data_in = 16'sd111;
        tick();
        check("start_cycle.en_out", 64'(voice_en_out), 64'd0);
        voice_data_in = 16'sd1234;
        tick();
        check("latency.en_out", 64'(voice_en_out), 64'd1);
        check("latency.data", 64'($unsigned(voice_data_out)), 64'(16'd1234));
        voice_en_in = 1'b0;
        tick();
        check("hold.en_out", 64'(voice_en_out), 64'd0);
        check("hold.data", 64'($unsigned(voice_data_out)), 64'(16'd1234));

        // Level just below the limit still forwards.
        wr_water_level = 12'd2046;
        voice_en_in    = 1'b1;
        voice_data_in  = 16'shFFFB;
        tick();
        check("level2046.en_out", 64'(voice_en_out), 64'd1);
        check("level2046.data", 64'($unsigned(voice_data_out)), 64'(16'hFFFB));
        check("level2046.overflow", 64'(overflow), 64'd0);
        voice_en_in = 1'b0;
        tick();

        // Backpressure: ten samples at the limit are dropped.
        wr_water_level = 12'd2047;
        base = fwd_total;
        for (int i = 0; i < 10; i++) begin
            voice_en_in   = 1'b1;
            voice_data_in = 16'sd77;
            tick();
        end
        voice_en_in = 1'b0;
        tick();
        check("bp.fwd_count", 64'(fwd_total - base), 64'd0);
        check("bp.overflow", 64'(overflow), 64'd1);
        check("bp.data_hold", 64'($unsigned(voice_data_out)), 64'(16'hFFFB));

        // Level drops: forwarding resumes, overflow stays sticky.
        wr_water_level = 12'd100;
        base = fwd_total;
        for (int i = 0; i < 5; i++) begin
            voice_en_in   = 1'b1;
            voice_data_in = 16'sd42;
            tick();
        end
        voice_en_in = 1'b0;
        tick();
        check("resume.fwd_count", 64'(fwd_total - base), 64'd5);
        check("resume.data", 64'($unsigned(voice_data_out)), 64'(16'd42));
        check("resume.overflow", 64'(overflow), 64'd1);

        // Abort mid-SPEECH: exactly one vq_stop, partial frame discarded.
        stop_before = stop_total;
        enable = 1'b0;
        tick();
        check("abort.vq_stop", 64'(vq_stop), 64'd1);
        check("abort.active", 64'(speech_active), 64'd0);
        tick();
        check("abort.vq_stop_once", 64'(vq_stop), 64'd0);
        check("abort.overflow_sticky", 64'(overflow), 64'd1);
        tick();
        check("abort.stop_count", 64'(stop_total - stop_before), 64'd1);
        enable = 1'b1;
        tick();
        run_frame("reenable", mk(T1, 16'sd500, EH, 0, 0, 0, 1, 0));
        run_frame("reonset1", mk(T1, 16'sd1000, E1, 0, 0, 0, 1, 0));
        run_frame("reonset2", mk(T1, 16'sd1000, E1, 0, 0, 0, 1, 0));
        run_frame("reonset3", mk(T1, 16'sd1000, E1, 1, 0, 1, 0, 0));
        tick();

        // Reset mid-frame during SPEECH with overflow set.
        wr_water_level = 12'd2047;
        voice_en_in    = 1'b1;
        voice_data_in  = 16'sd9;
        tick();
        check("prereset.overflow", 64'(overflow), 64'd1);
        wr_water_level = 12'd100;
        for (int i = 0; i < 100; i++) begin
            voice_data_in = 16'sd1000;
            tick();
        end
        stop_before = stop_total;
        #2 rst_n = 1'b0;
        #1;
        check("midreset.en_out", 64'(voice_en_out), 64'd0);
        check("midreset.data", 64'($unsigned(voice_data_out)), 64'd0);
        check("midreset.active", 64'(speech_active), 64'd0);
        check("midreset.overflow", 64'(overflow), 64'd0);
        check("midreset.energy", 64'(frame_energy), 64'd0);
        check("midreset.vq_stop", 64'(vq_stop), 64'd0);
        voice_en_in = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) tick();
        check("midreset.no_stop", 64'(stop_total - stop_before), 64'd0);
        run_frame("postreset", mk(T1, 16'sd500, EH, 0, 0, 0, 0, 0));

        check("start_stop_clash", 64'(clash_total), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/voice_endpoint_detect.md
Name: voice_endpoint_detect

Overview:
Upstream stage of the MFCC/VQ speaker-recognition path. It computes short-time frame energy on the incoming PCM stream and runs a hysteresis state machine to find speech endpoints. It generates the VQ_START/VQ_STOP strobes consumed by MFCC_VQ. Between those strobes it forwards samples to MFCC_VQ's voice_en_in/voice_data_in, gated by MFCC_VQ's wr_water_level.

Parameters:
DATA_WIDTH, 16, signed PCM sample width
FRAME_LEN, 256, samples per energy frame (power of 2, >=2)
ENERGY_W, 40, energy accumulator/output width (must hold FRAME_LEN*2^(2*DATA_WIDTH-2))
ON_FRAMES, 3, consecutive loud frames required to declare speech (>=1)
OFF_FRAMES, 8, consecutive quiet frames required to end speech (>=1)
LEVEL_MAX, 2047, forward only while wr_water_level < LEVEL_MAX

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  detector enable; level
energy_thr  in  ENERGY_W  frame "loud" threshold, unsigned
voice_en_in  in  1  input sample strobe
voice_data_in  in  DATA_WIDTH  signed sample
wr_water_level  in  12  MFCC_VQ input FIFO fill level
voice_en_out  out  1  forwarded sample strobe
voice_data_out  out  DATA_WIDTH  forwarded sample
vq_start  out  1  one-cycle pulse at speech onset
vq_stop  out  1  one-cycle pulse at speech end
speech_active  out  1  high in SPEECH or HANGOVER
overflow  out  1  sticky: a sample was dropped on FIFO level
frame_energy  out  ENERGY_W  last completed frame energy
frame_energy_vld  out  1  one-cycle pulse, frame_energy updated

Behaviour:
- Reset (async): all outputs 0, accumulator 0, sample counter 0, state IDLE.
- Energy: sq = voice_data_in*voice_data_in (signed; unsigned 2*DATA_WIDTH result, max 2^30 for 16 bit). On each voice_en_in, acc += sq and cnt++. On the FRAME_LEN-th sample, the next cycle frame_energy = acc+sq and frame_energy_vld=1. acc and cnt restart at 0 with no lost sample. No saturation needed (width guaranteed by parameter).
- loud = frame_energy > energy_thr (strict). Evaluated only in the frame_energy_vld cycle. State updates on the following edge.
- States: IDLE, SILENCE, ONSET, SPEECH, HANGOVER; frame counter fc.
  - IDLE: enable=1 -> SILENCE. acc and cnt are held at 0 while in IDLE.
  - SILENCE: loud -> ONSET with fc=1. If ON_FRAMES==1, go directly to SPEECH with vq_start.
  - ONSET: loud -> fc++. When fc reaches ON_FRAMES -> SPEECH and vq_start=1 for one cycle. Quiet -> SILENCE, fc=0.
  - SPEECH: quiet -> HANGOVER with fc=1. If OFF_FRAMES==1, go directly to SILENCE with vq_stop.
  - HANGOVER: loud -> SPEECH, fc=0, no pulse. Quiet -> fc++. When fc reaches OFF_FRAMES -> SILENCE and vq_stop=1.
  - enable=0 in any state -> IDLE. If leaving SPEECH/HANGOVER, vq_stop=1 once. acc and cnt are cleared.
- vq_start and vq_stop are never high in the same cycle. At most one vq_stop follows each vq_start.
- Forwarding: while speech_active, each voice_en_in sample with wr_water_level < LEVEL_MAX appears one cycle later as voice_en_out=1 with voice_data_out = the sample. Otherwise the sample is dropped and overflow is set to 1.
  - overflow clears only on vq_start or reset.
  - voice_data_out holds its last value when voice_en_out=0.
- The first forwarded sample is the first voice_en_in that arrives after the vq_start cycle. Samples in the vq_stop cycle are not forwarded.
- Energy accumulation continues during forwarding and is independent of the water level.
- Reset mid-operation: everything returns to reset values immediately, with no vq_stop emitted.

Test Plan:
- Onset: thr=100,000,000; 3 frames of constant 1000 -> each frame_energy=256,000,000; vq_start one cycle after the 3rd frame_energy_vld; speech_active=1; next sample forwarded with 1-cycle latency.
- No false onset: 2 loud frames (1000), then 1 frame of 0 -> no vq_start, state SILENCE, frame_energy=0.
- Hangover: in SPEECH, 7 zero frames then 1 loud frame -> no vq_stop. Then 8 zero frames -> vq_stop one cycle after the 8th vld; speech_active=0; no further voice_en_out.
- Backpressure: in SPEECH, wr_water_level=2047 for 10 samples -> no voice_en_out, overflow=1. Level 100 -> forwarding resumes, overflow stays 1 until the next vq_start.
- Width: 256 samples of -32768 -> frame_energy=2^38 (274,877,906,944), no wrap.
- Abort: enable=0 mid-SPEECH -> single vq_stop, IDLE, acc cleared. rst_n pulse mid-frame -> all outputs 0 at once, no vq_stop.
